// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the iterative AES-128 encryption controller:
//   NR        - number of cipher rounds (AES-128 only)
//   BLOCK_W   - width of a state block / round key
//   KSCHED_W  - width of the expanded key schedule bus ((NR+1) round keys)
//   state_t   - controller FSM states
//   round_key - selects round key r from the expanded key schedule
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int NR       = 10;
  localparam int BLOCK_W  = 128;
  localparam int KSCHED_W = 1408;

  typedef enum logic {
    IDLE  = 1'b0,
    ROUND = 1'b1
  } state_t;

  // Round key r lives at words[BLOCK_W*r +: BLOCK_W] (bit 0 = MSB of key 0).
  // Built as a mux over constant slices so an out-of-range round (never
  // reached in practice) yields zero instead of an out-of-bounds select.
  function automatic logic [0:BLOCK_W-1] round_key(
    input logic [0:KSCHED_W-1] words,
    input logic [3:0]          round
  );
    logic [0:BLOCK_W-1] key;
    key = '0;
    for (int r = 0; r <= NR; r++) begin
      if (round == 4'(r)) key = words[BLOCK_W*r +: BLOCK_W];
    end
    return key;
  endfunction

endpackage

// File: rtl/aes_out_slot.sv
// ---------------------------------------------------------------------------
// aes_out_slot
// Single-entry output register for ciphertext blocks with valid/ready
// backpressure. A load always wins over a drain in the same cycle, so a
// simultaneous drain and load leaves out_valid high with the new block.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - write load_block into the slot this edge
//   load_block  - block to store
//   out_ready   - consumer accepts the held block
//   out_valid   - slot holds a block
//   out_block   - held block, stable while out_valid && !out_ready
//   free        - slot can accept a load this cycle (empty or draining)
// ---------------------------------------------------------------------------
module aes_out_slot
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [0:BLOCK_W-1] load_block,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [0:BLOCK_W-1] out_block,
  output logic               free
);

  assign free = !out_valid || out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_block <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_block <= load_block;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
// Sequencing controller for an iterative AES-128 encryption datapath. Accepts
// a plaintext block, applies the initial AddRoundKey, then steps an external
// combinational round function through rounds 1..NR and parks the ciphertext
// in a single-entry output slot.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   in_valid    - plaintext offered          in_ready  - block can be accepted
//   in_block    - plaintext (bit 0 = MSB)
//   words       - expanded key schedule, held stable while busy
//   st          - state register, feeds the round function
//   rk          - round key for the current round (combinational)
//   round       - current round, 0 in IDLE
//   last_round  - round == NR, round function skips MixColumns
//   rnd_res     - round-function result for (st, rk, last_round)
//   out_valid   - ciphertext available       out_ready - consumer takes it
//   out_block   - ciphertext
//   busy        - FSM is in ROUND
// ---------------------------------------------------------------------------
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = aes_pkg::NR  // only 10 (AES-128) is supported
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [0:BLOCK_W-1]  in_block,
  input  logic [0:KSCHED_W-1] words,
  output logic [0:BLOCK_W-1]  st,
  output logic [0:BLOCK_W-1]  rk,
  output logic [3:0]          round,
  output logic                last_round,
  input  logic [0:BLOCK_W-1]  rnd_res,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [0:BLOCK_W-1]  out_block,
  output logic                busy
);

  localparam logic [3:0] LAST = 4'(NR);

  state_t             state_q, state_d;
  logic [3:0]         round_d;
  logic [0:BLOCK_W-1] st_d;
  logic               slot_load;
  logic               slot_free;

  // State register (FSM state plus the round counter and state block).
  // NOTE: st is a datapath register but is still reset, so a reset mid-block
  // leaves no stale plaintext-derived value on the round-function input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round   <= '0;
      st      <= '0;
    end else begin
      state_q <= state_d;
      round   <= round_d;
      st      <= st_d;
    end
  end

  // Next-state logic.
  // NOTE: every signal gets a hold default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    round_d   = round;
    st_d      = st;
    slot_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Initial AddRoundKey with round key 0.
          st_d    = in_block ^ words[0:BLOCK_W-1];
          round_d = 4'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (round != LAST) begin
          st_d    = rnd_res;
          round_d = round + 4'd1;
        end else if (slot_free) begin
          // Final round result goes straight to the output slot; st keeps
          // its value since nothing consumes it in IDLE.
          slot_load = 1'b1;
          round_d   = 4'd0;
          state_d   = IDLE;
        end
        // Otherwise stall at round NR until the slot frees.
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    in_ready   = (state_q == IDLE);
    busy       = (state_q == ROUND);
    last_round = (round == LAST);
    rk         = round_key(words, round);
  end

  aes_out_slot u_out_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (slot_load),
    .load_block (rnd_res),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_block  (out_block),
    .free       (slot_free)
  );

endmodule

// File: tb/tb_aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_round_ctrl
// Directed bench for aes_round_ctrl. Supplies a behavioural AES key
// expansion and round function so the controller can be exercised end to
// end; the FIPS-197 vector provides the hand-known ciphertext.
// ---------------------------------------------------------------------------
module tb_aes_round_ctrl;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [0:127]   in_block;
  logic [0:1407]  words;
  logic [0:127]   st;
  logic [0:127]   rk;
  logic [3:0]     round;
  logic           last_round;
  logic [0:127]   rnd_res;
  logic           out_valid;
  logic           out_ready;
  logic [0:127]   out_block;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;
  int words_bad = 0;
  logic [0:1407] words_q;

  aes_round_ctrl #(.NR(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_block   (in_block),
    .words      (words),
    .st         (st),
    .rk         (rk),
    .round      (round),
    .last_round (last_round),
    .rnd_res    (rnd_res),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_block  (out_block),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- AES reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse (x^254) then affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = x;
    for (int i = 0; i < 253; i++) b = gmul(b, x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [0:1407] key_expand(input logic [0:127] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [0:1407] ks;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) ks[32*i +: 32] = w[i];
    return ks;
  endfunction

  function automatic logic [0:127] round_fn(input logic [0:127] s_in,
                                            input logic [0:127] key,
                                            input logic         last);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [0:127] o;
    for (int i = 0; i < 16; i++) s[i] = sbox(s_in[8*i +: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r + 4*c] = s[r + 4*((c + r) % 4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) o[8*i +: 8] = t[i];
    return o ^ key;
  endfunction

  // State after the initial AddRoundKey and n full rounds.
  function automatic logic [0:127] model_state(input logic [0:127]  pt,
                                               input logic [0:1407] ks,
                                               input int            n);
    logic [0:127] s;
    s = pt ^ ks[0:127];
    for (int r = 1; r <= n; r++) s = round_fn(s, ks[128*r +: 128], r == 10);
    return s;
  endfunction

  // External combinational round function driven by the controller.
  always_comb rnd_res = round_fn(st, rk, last_round);

  // Key schedule must not move while a block is in flight.
  always @(posedge clk) begin
    if (rst_n && busy && words != words_q) words_bad <= words_bad + 1;
    words_q <= words;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [0:127] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] PT2  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [0:127] PT3  = 128'hdeadbeefcafef00d0badc0de12345678;

  logic [0:1407] kw;
  logic [0:1407] alt;
  logic [0:127]  ct2, ct3, st9;
  int            cnt;
  logic          seen;

  initial begin
    kw  = key_expand(KEY);
    alt = {11{128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0}};
    ct2 = model_state(PT2, kw, 10);
    ct3 = model_state(PT3, kw, 10);
    st9 = model_state(PT1, kw, 9);

    rst_n = 1'b0; in_valid = 1'b0; in_block = '0; out_ready = 1'b1;
    words = kw;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_round", 128'(round), 128'd0);
    check("rst_st", st, 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_block", out_block, 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_rk", rk, KEY);
    rst_n = 1'b1;

    // Idle key select: rk follows words[0:127], no state change
    step();
    words = alt;
    #1;
    check("idle_rk_alt", rk, alt[0:127]);
    step();
    step();
    check("idle_round", 128'(round), 128'd0);
    check("idle_st", st, 128'd0);
    check("idle_busy", 128'(busy), 128'd0);
    words = kw;
    #1;
    check("idle_rk_kw", rk, KEY);

    // Basic FIPS-197 vector, latency and round sequencing
    in_valid = 1'b1; in_block = PT1;
    step();
    in_valid = 1'b0;
    check("acc_st", st, PT1 ^ KEY);
    check("acc_busy", 128'(busy), 128'd1);
    check("acc_in_ready", 128'(in_ready), 128'd0);
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("seq_round_%0d", k), 128'(round), 128'(k));
      check($sformatf("seq_last_%0d", k), 128'(last_round), 128'(k == 10));
      check($sformatf("seq_noval_%0d", k), 128'(out_valid), 128'd0);
      step();
    end
    check("basic_out_valid", 128'(out_valid), 128'd1);
    check("basic_out_block", out_block, CT1);
    check("basic_round0", 128'(round), 128'd0);
    check("basic_in_ready", 128'(in_ready), 128'd1);

    // Back-to-back with in_valid held high
    in_valid = 1'b1; in_block = PT1;
    step();
    in_block = PT2;
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      step();
      cnt++;
    end
    check("b2b_gap", 128'(cnt + 1), 128'd11);
    check("b2b_first_valid", 128'(out_valid), 128'd1);
    check("b2b_first_block", out_block, CT1);
    step();
    in_valid = 1'b0;
    check("b2b_drained", 128'(out_valid), 128'd0);
    check("b2b_round1", 128'(round), 128'd1);
    repeat (10) step();
    check("b2b_second_valid", 128'(out_valid), 128'd1);
    check("b2b_second_block", out_block, ct2);

    // Backpressure: first ciphertext held while second stalls at round 10
    step();
    check("bp_drain", 128'(out_valid), 128'd0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_block = PT3;
    step();
    in_block = PT1;
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      step();
      cnt++;
    end
    check("bp_wait", 128'(cnt), 128'd10);
    check("bp_first_valid", 128'(out_valid), 128'd1);
    check("bp_first_block", out_block, ct3);
    step();
    in_valid = 1'b0;
    repeat (9) step();
    check("bp_round10", 128'(round), 128'd10);
    check("bp_st9", st, st9);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("bp_hold_round_%0d", k), 128'(round), 128'd10);
      check($sformatf("bp_hold_st_%0d", k), st, st9);
      check($sformatf("bp_hold_block_%0d", k), out_block, ct3);
      check($sformatf("bp_hold_valid_%0d", k), 128'(out_valid), 128'd1);
      check($sformatf("bp_hold_busy_%0d", k), 128'(busy), 128'd1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_swap_valid", 128'(out_valid), 128'd1);
    check("bp_swap_block", out_block, CT1);
    check("bp_swap_round", 128'(round), 128'd0);
    check("bp_swap_idle", 128'(in_ready), 128'd1);

    // Reset mid-run at round 5, with a ciphertext still parked in the slot
    in_valid = 1'b1; in_block = PT2;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    check("mr_round5", 128'(round), 128'd5);
    check("mr_slot_full", 128'(out_valid), 128'd1);
    rst_n = 1'b0;
    #1;
    check("mr_round", 128'(round), 128'd0);
    check("mr_st", st, 128'd0);
    check("mr_out_valid", 128'(out_valid), 128'd0);
    check("mr_out_block", out_block, 128'd0);
    check("mr_in_ready", 128'(in_ready), 128'd1);
    check("mr_busy", 128'(busy), 128'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    check("mr_no_out_valid", 128'(seen), 128'd0);

    in_valid = 1'b1; in_block = PT3;
    step();
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      step();
      cnt++;
    end
    check("mr_next_latency", 128'(cnt), 128'd10);
    check("mr_next_block", out_block, ct3);

    check("words_stable_busy", 128'(words_bad), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
